// File: rtl/pool_pkg.sv
// -----------------------------------------------------------------------------
// pool_pkg
// Shared definitions for the pooling write-back stage.
//   DATA_WIDTH : default width of one pooled value
//   COL        : default number of pooling columns
//   state_t    : write-back controller states
//   row_t      : one aligned output row at the default geometry,
//                column 0 in the least significant DATA_WIDTH bits
// -----------------------------------------------------------------------------
package pool_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int COL        = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [COL*DATA_WIDTH-1:0] row_t;

endpackage : pool_pkg

// File: rtl/pool_writeback_if.sv
// -----------------------------------------------------------------------------
// pool_writeback_if
// Row write bus between the write-back stage and the output feature-map
// memory. Valid/ready handshake: a row transfers on a cycle where both
// wr_en and wr_ready are high.
//   wr_en    : row write valid             (master -> slave)
//   wr_addr  : row address                 (master -> slave)
//   wr_data  : row data, column 0 in LSBs  (master -> slave)
//   wr_ready : memory accepts this cycle   (slave  -> master)
// -----------------------------------------------------------------------------
interface pool_writeback_if
    import pool_pkg::*;
#(
    parameter int addr_width = 10,
    parameter int row_width  = DATA_WIDTH * COL
);

    logic                  wr_en;
    logic [addr_width-1:0] wr_addr;
    logic [row_width-1:0]  wr_data;
    logic                  wr_ready;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );

endinterface : pool_writeback_if

// File: rtl/pool_row_fifo.sv
// -----------------------------------------------------------------------------
// pool_row_fifo
// Synchronous show-ahead FIFO holding complete output rows.
//   clk, nrst : clock, asynchronous active-low reset (pointers only)
//   i_push    : write i_din; taken when not full, or when full with a
//               same-cycle pop
//   i_pop     : retire the head entry; ignored when empty
//   i_din     : row to store
//   o_dout    : current head entry (valid while !o_empty)
//   o_full    : depth entries stored
//   o_empty   : no entries stored
// -----------------------------------------------------------------------------
module pool_row_fifo #(
    parameter int width = 512,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [width-1:0] i_din,
    output logic [width-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int            aw      = $clog2(depth);
    localparam logic [aw:0]   ptr_one = 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [aw:0]      r_wptr;
    logic [aw:0]      r_rptr;
    logic [width-1:0] r_mem [depth];

    logic w_do_push;
    logic w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[aw] != r_rptr[aw]) &&
                       (r_wptr[aw-1:0] == r_rptr[aw-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_dout    = r_mem[r_rptr[aw-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + ptr_one;
            if (w_do_pop)  r_rptr <= r_rptr + ptr_one;
        end
    end

    // NOTE: storage is deliberately not reset; validity is tracked by the
    // pointers alone, which keeps the array mappable to plain RAM/flops.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[aw-1:0]] <= i_din;
    end

endmodule : pool_row_fifo

// File: rtl/pool_writeback.sv
// -----------------------------------------------------------------------------
// pool_writeback
// Downstream stage of the pooling unit array. Column j of a row strobes one
// cycle after column j-1. Each column's result is parked in one of two row
// banks (ping-pong per column) until the last column strobes; the aligned
// row is then pushed to a small FIFO and written to consecutive addresses
// of the output feature-map memory.
//   clk, nrst    : clock, asynchronous active-low reset
//   i_start      : one-cycle pulse in IDLE; latches i_base_addr/i_num_rows
//   i_base_addr  : address of the first output row
//   i_num_rows   : rows expected in this layer (0 allowed)
//   i_pool_out   : per-column pooled value
//   i_pool_done  : per-column result strobe, skewed one cycle per column
//   wr_bus       : row write master (wr_en/wr_addr/wr_data, wr_ready)
//   o_busy       : high in RUN and DRAIN
//   o_done       : one-cycle pulse at end of layer
//   o_overflow   : sticky; a row was dropped on a full FIFO
// -----------------------------------------------------------------------------
module pool_writeback
    import pool_pkg::*;
#(
    parameter int data_width = DATA_WIDTH,
    parameter int col        = COL,
    parameter int addr_width = 10,
    parameter int fifo_depth = 4
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  i_start,
    input  logic [addr_width-1:0] i_base_addr,
    input  logic [addr_width-1:0] i_num_rows,
    input  logic [data_width-1:0] i_pool_out  [col],
    input  logic                  i_pool_done [col],
    pool_writeback_if.master      wr_bus,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overflow
);

    localparam int                    row_width = col * data_width;
    localparam logic [addr_width-1:0] addr_one  = 1;

    state_t                r_state;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_overflow;
    logic [addr_width-1:0] r_base;
    logic [addr_width-1:0] r_num_rows;
    logic [addr_width-1:0] r_rows_in;
    logic [addr_width-1:0] r_rows_out;

    // The last column is never parked: it is taken live on the completing edge.
    logic [data_width-1:0] r_bank_a [col-1];
    logic [data_width-1:0] r_bank_b [col-1];
    logic [col-1:0]        r_sel;

    logic                  w_start_ok;
    logic                  w_accept;
    logic                  w_row_done;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [row_width-1:0]  w_row;
    logic [row_width-1:0]  w_head;

    assign w_start_ok = (r_state == IDLE) && i_start;
    // Strobes count only while the layer still expects rows.
    assign w_accept   = (r_state == RUN) && (r_rows_in != r_num_rows);
    assign w_row_done = w_accept && i_pool_done[col-1];
    assign w_pop      = !w_empty && wr_bus.wr_ready;
    assign w_push     = w_row_done && (!w_full || w_pop);

    // Every column of one row toggles its select bit exactly once, so the
    // last column's bit names the bank that holds the rest of the row.
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    always_comb begin
        w_row = '0;
        for (int j = 0; j < col - 1; j++) begin
            w_row[j*data_width +: data_width] = r_sel[col-1] ? r_bank_b[j] : r_bank_a[j];
        end
        w_row[(col-1)*data_width +: data_width] = i_pool_out[col-1];
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < col - 1; j++) begin
            if (w_accept && i_pool_done[j]) begin
                if (r_sel[j]) r_bank_b[j] <= i_pool_out[j];
                else          r_bank_a[j] <= i_pool_out[j];
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sel <= '0;
        end else if (w_start_ok) begin
            r_sel <= '0;
        end else begin
            for (int j = 0; j < col; j++) begin
                if (w_accept && i_pool_done[j]) r_sel[j] <= ~r_sel[j];
            end
        end
    end

    pool_row_fifo #(
        .width (row_width),
        .depth (fifo_depth)
    ) u_fifo (
        .clk     (clk),
        .nrst    (nrst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_row),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_base     <= '0;
            r_num_rows <= '0;
            r_rows_in  <= '0;
            r_rows_out <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_pop) r_rows_out <= r_rows_out + addr_one;
            // A dropped row still counts toward the layer so it can finish.
            if (w_row_done) begin
                r_rows_in <= r_rows_in + addr_one;
                if (w_full && !w_pop) r_overflow <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state    <= RUN;
                        r_busy     <= 1'b1;
                        r_base     <= i_base_addr;
                        r_num_rows <= i_num_rows;
                        r_rows_in  <= '0;
                        r_rows_out <= '0;
                        r_overflow <= 1'b0;
                    end
                end
                RUN: begin
                    if (r_rows_in == r_num_rows) r_state <= DRAIN;
                end
                DRAIN: begin
                    if (w_empty) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Address and data are forced to zero while nothing is offered so the
    // bus reads all-zero out of reset even though FIFO storage is not reset.
    assign wr_bus.wr_en   = !w_empty;
    assign wr_bus.wr_addr = w_empty ? '0 : (r_base + r_rows_out);
    assign wr_bus.wr_data = w_empty ? '0 : w_head;

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_overflow = r_overflow;

endmodule : pool_writeback

// File: tb/tb_pool_writeback.sv
// -----------------------------------------------------------------------------
// tb_pool_writeback
// Directed bench for pool_writeback at the default geometry (16-bit values,
// 32 columns, 10-bit addresses, 4-row FIFO). Column j of row r carries
// r*100+j, so every expected row is known in advance.
// -----------------------------------------------------------------------------
module tb_pool_writeback;
    import pool_pkg::*;

    localparam int DW = 16;
    localparam int NC = 32;
    localparam int AW = 10;
    localparam int FD = 4;

    logic          clk  = 1'b0;
    logic          nrst = 1'b0;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] num_rows;
    logic [DW-1:0] pool_out  [NC];
    logic          pool_done [NC];
    logic          busy;
    logic          done;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    pool_writeback_if #(.addr_width(AW), .row_width(DW*NC)) wr_bus ();

    pool_writeback #(
        .data_width (DW),
        .col        (NC),
        .addr_width (AW),
        .fifo_depth (FD)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .i_start     (start),
        .i_base_addr (base_addr),
        .i_num_rows  (num_rows),
        .i_pool_out  (pool_out),
        .i_pool_done (pool_done),
        .wr_bus      (wr_bus),
        .o_busy      (busy),
        .o_done      (done),
        .o_overflow  (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Observed write transfers and done pulses, sampled on the falling edge.
    typedef struct {
        logic [AW-1:0] addr;
        row_t          data;
        int            cyc;
    } wr_rec_t;

    wr_rec_t wr_q[$];
    int      done_q[$];
    int      strobe_q[$];
    int      wen_cnt = 0;

    always @(negedge clk) begin
        wr_rec_t rec;
        if (nrst) begin
            if (wr_bus.wr_en) wen_cnt++;
            if (wr_bus.wr_en && wr_bus.wr_ready) begin
                rec.addr = wr_bus.wr_addr;
                rec.data = wr_bus.wr_data;
                rec.cyc  = cyc;
                wr_q.push_back(rec);
            end
            if (done) done_q.push_back(cyc);
        end
    end

    function automatic row_t exp_row(input int r);
        row_t v;
        v = '0;
        for (int j = 0; j < NC; j++) v[j*DW +: DW] = DW'(r*100 + j);
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_q.delete();
        done_q.delete();
        strobe_q.delete();
    endtask

    task automatic do_start(input logic [AW-1:0] base, input logic [AW-1:0] rows);
        start     = 1'b1;
        base_addr = base;
        num_rows  = rows;
        tick(1);
        start     = 1'b0;
    endtask

    // Row r, column j strobes at relative cycle r*period + j.
    task automatic feed_rows(input int nrows, input int period);
        int last;
        last = (nrows - 1) * period + NC - 1;
        for (int t = 0; t <= last; t++) begin
            for (int j = 0; j < NC; j++) begin
                int d;
                d = t - j;
                pool_done[j] = 1'b0;
                if (d >= 0 && (d % period) == 0 && (d / period) < nrows) begin
                    pool_done[j] = 1'b1;
                    pool_out[j]  = DW'((d / period) * 100 + j);
                    if (j == NC - 1) strobe_q.push_back(cyc);
                end
            end
            tick(1);
        end
        for (int j = 0; j < NC; j++) pool_done[j] = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_q.size() == 0; i++) tick(1);
        tick(2);
    endtask

    // Compares the write log against rows 0..n-1 at base+i.
    task automatic check_writes(input string tag, input logic [AW-1:0] base, input int n,
                                input bit check_latency);
        logic [AW-1:0] exp_a;
        n_checks++;
        if (wr_q.size() !== n) begin
            n_fail++;
            $display("FAIL %s_count: got %0d writes, want %0d", tag, wr_q.size(), n);
        end
        for (int i = 0; i < n; i++) begin
            if (i < wr_q.size()) begin
                exp_a = base + AW'(i);
                n_checks++;
                if (wr_q[i].addr !== exp_a) begin
                    n_fail++;
                    $display("FAIL %s_addr%0d: got %h want %h", tag, i, wr_q[i].addr, exp_a);
                end
                n_checks++;
                if (wr_q[i].data !== exp_row(i)) begin
                    n_fail++;
                    $display("FAIL %s_data%0d: got %h want %h", tag, i, wr_q[i].data, exp_row(i));
                end
                if (check_latency && i < strobe_q.size()) begin
                    n_checks++;
                    if (wr_q[i].cyc !== strobe_q[i] + 1) begin
                        n_fail++;
                        $display("FAIL %s_latency%0d: write in cycle %0d want %0d",
                                 tag, i, wr_q[i].cyc, strobe_q[i] + 1);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        start           = 1'b0;
        base_addr       = '0;
        num_rows        = '0;
        wr_bus.wr_ready = 1'b0;
        for (int j = 0; j < NC; j++) begin
            pool_done[j] = 1'b0;
            pool_out[j]  = '0;
        end
        tick(3);
        n_checks++;
        if ({wr_bus.wr_en, busy, done, overflow} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got en/busy/done/ovf=%b want 0000",
                     {wr_bus.wr_en, busy, done, overflow});
        end
        n_checks++;
        if (wr_bus.wr_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_addr: got %h want 000", wr_bus.wr_addr);
        end
        n_checks++;
        if (wr_bus.wr_data !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0", wr_bus.wr_data);
        end
        @(negedge clk) nrst = 1'b1;
        tick(2);
    endtask

    task automatic test_basic();
        clear_logs();
        wr_bus.wr_ready = 1'b1;
        do_start(10'h010, 10'd3);
        feed_rows(3, 40);
        wait_done(100);
        check_writes("basic", 10'h010, 3, 1'b1);
        n_checks++;
        if (done_q.size() !== 1) begin
            n_fail++;
            $display("FAIL basic_done: got %0d pulses want 1", done_q.size());
        end
        n_checks++;
        if ({busy, overflow} !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_idle: got busy/ovf=%b want 00", {busy, overflow});
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        wr_bus.wr_ready = 1'b1;
        do_start(10'h040, 10'd3);
        feed_rows(3, 16);
        wait_done(100);
        check_writes("b2b", 10'h040, 3, 1'b1);
        n_checks++;
        if (done_q.size() !== 1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: got %0d done pulses ovf=%b want 1, 0", done_q.size(), overflow);
        end
    endtask

    task automatic test_stall();
        logic [AW-1:0] held_a;
        row_t          held_d;
        clear_logs();
        wr_bus.wr_ready = 1'b0;
        do_start(10'h100, 10'd6);
        feed_rows(6, 16);
        held_a = wr_bus.wr_addr;
        held_d = wr_bus.wr_data;
        n_checks++;
        if (held_a !== 10'h100 || held_d !== exp_row(0)) begin
            n_fail++;
            $display("FAIL stall_head: got addr %h data %h want 100 / %h", held_a, held_d, exp_row(0));
        end
        tick(20);
        n_checks++;
        if (wr_bus.wr_en !== 1'b1 || wr_bus.wr_addr !== held_a || wr_bus.wr_data !== held_d) begin
            n_fail++;
            $display("FAIL stall_hold: got en %b addr %h want 1 / %h", wr_bus.wr_en, wr_bus.wr_addr, held_a);
        end
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_overflow: got %b want 1", overflow);
        end
        wr_bus.wr_ready = 1'b1;
        wait_done(100);
        check_writes("stall", 10'h100, 4, 1'b0);
        n_checks++;
        if (done_q.size() !== 1 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_end: got %0d done pulses ovf=%b want 1, 1", done_q.size(), overflow);
        end
    endtask

    task automatic test_wrap();
        clear_logs();
        wr_bus.wr_ready = 1'b1;
        do_start(10'h3FE, 10'd4);
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_ovf_clear: got %b want 0", overflow);
        end
        feed_rows(4, 16);
        wait_done(100);
        check_writes("wrap", 10'h3FE, 4, 1'b1);
    endtask

    task automatic test_zero_rows();
        int s;
        int wen0;
        clear_logs();
        wen0            = wen_cnt;
        wr_bus.wr_ready = 1'b1;
        s               = cyc;
        start           = 1'b1;
        base_addr       = 10'h080;
        num_rows        = 10'd0;
        tick(1);
        // Second start while RUN, with a row count that would never finish.
        base_addr = 10'h090;
        num_rows  = 10'd5;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_busy: got %b want 1", busy);
        end
        tick(1);
        start = 1'b0;
        tick(6);
        n_checks++;
        if (done_q.size() !== 1) begin
            n_fail++;
            $display("FAIL zero_done_count: got %0d want 1", done_q.size());
        end else begin
            n_checks++;
            if (done_q[0] !== s + 3) begin
                n_fail++;
                $display("FAIL zero_done_cycle: got %0d want %0d", done_q[0], s + 3);
            end
        end
        n_checks++;
        if (wen_cnt !== wen0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_quiet: got %0d wr_en cycles busy=%b want 0, 0", wen_cnt - wen0, busy);
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        wr_bus.wr_ready = 1'b0;
        do_start(10'h200, 10'd5);
        feed_rows(2, 16);
        tick(2);
        n_checks++;
        if ({wr_bus.wr_en, busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL rmid_before: got en/busy=%b want 11", {wr_bus.wr_en, busy});
        end
        #2 nrst = 1'b0;
        #1;
        n_checks++;
        if ({wr_bus.wr_en, busy, done, overflow} !== 4'b0000 ||
            wr_bus.wr_addr !== '0 || wr_bus.wr_data !== '0) begin
            n_fail++;
            $display("FAIL rmid_async: got en/busy/done/ovf=%b addr %h want 0000 / 000",
                     {wr_bus.wr_en, busy, done, overflow}, wr_bus.wr_addr);
        end
        @(negedge clk) nrst = 1'b1;
        tick(2);
        clear_logs();
        wr_bus.wr_ready = 1'b1;
        do_start(10'h020, 10'd2);
        feed_rows(2, 16);
        wait_done(100);
        check_writes("rmid", 10'h020, 2, 1'b1);
        n_checks++;
        if (done_q.size() !== 1) begin
            n_fail++;
            $display("FAIL rmid_done: got %0d pulses want 1", done_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_wrap();
        test_zero_rows();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish by time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_pool_writeback
